// File: rtl/trp_ctrl.sv
// Transpose-buffer controller: writes one tile of row beats into trp_fifo, then
// reads back the column beats through a 2-entry skid FIFO onto a valid/ready stream.
module trp_ctrl #(
  parameter int BUFFD = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BUFFD*8-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BUFFD*8-1:0] m_data,
  output logic               m_last,
  output logic               busy,
  output logic               err_mode,
  output logic [1:0]         trp_mode,
  output logic               ffinit,
  output logic               ffwreq,
  output logic [BUFFD*8-1:0] ffwdata,
  output logic               ffrreq,
  input  logic [BUFFD*8-1:0] ffrdata,
  input  logic               ffrvld
);
  localparam int W  = BUFFD*8;
  localparam int CW = $clog2(BUFFD+1);

  typedef enum logic [1:0] {IDLE, INIT, FILL, DRAIN} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_trp_mode;
  logic [CW-1:0]   r_wr_cnt, r_rd_cnt;
  logic            r_pend, r_pend_last;
  logic [W-1:0]    r_skid_data [2];
  logic [1:0]      r_skid_last;
  logic            r_wptr, r_rptr;
  logic [1:0]      r_skid_cnt;

  logic            w_legal, w_acc, w_pop, w_push, w_rreq;
  logic [CW-1:0]   w_n, w_n_m1;
  logic [2:0]      w_occ;

  assign w_legal = (mode == 2'b01) || (mode == 2'b10);
  assign w_n     = (r_trp_mode == 2'b10) ? CW'(BUFFD/4) : CW'(BUFFD);
  assign w_n_m1  = w_n - CW'(1);
  assign w_acc   = (r_state == FILL) && s_valid;
  assign m_valid = (r_skid_cnt != 2'd0);
  assign w_pop   = m_valid && m_ready;
  assign w_push  = ffrvld && (r_state == DRAIN) && (r_skid_cnt != 2'd2);
  // Occupancy next cycle once the in-flight read lands; counting this cycle's pop
  // keeps one beat per cycle streaming while m_ready stays high.
  assign w_occ   = 3'(r_skid_cnt) + 3'(r_pend) - 3'(w_pop);
  assign w_rreq  = (r_state == DRAIN) && (r_rd_cnt < w_n) && (w_occ < 3'd2);

  assign m_data   = m_valid ? r_skid_data[r_rptr] : '0;
  assign m_last   = m_valid && r_skid_last[r_rptr];
  assign trp_mode = r_trp_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (s_valid && w_legal)         w_next = INIT;
      INIT:                                  w_next = FILL;
      FILL:  if (w_acc && r_wr_cnt == w_n_m1) w_next = DRAIN;
      DRAIN: if (w_pop && m_last)            w_next = IDLE;
      default:                               w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    ffinit   = 1'b0;
    ffwreq   = 1'b0;
    ffwdata  = '0;
    ffrreq   = 1'b0;
    err_mode = 1'b0;
    busy     = (r_state != IDLE);
    case (r_state)
      IDLE:  err_mode = s_valid && !w_legal;
      INIT:  ffinit   = 1'b1;
      FILL:  begin
        s_ready = 1'b1;
        ffwreq  = s_valid;
        ffwdata = s_data;
      end
      DRAIN: ffrreq = w_rreq;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trp_mode  <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      if (r_state == IDLE && s_valid && w_legal) r_trp_mode <= mode;
      if (r_state == INIT) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (w_acc)  r_wr_cnt <= r_wr_cnt + CW'(1);
        if (w_rreq) r_rd_cnt <= r_rd_cnt + CW'(1);
      end
      r_pend      <= w_rreq;
      r_pend_last <= w_rreq && (r_rd_cnt == w_n_m1);
    end
  end

  // Skid FIFO; the last-beat tag travels with the read request into the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_data[0] <= '0;
      r_skid_data[1] <= '0;
      r_skid_last    <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_skid_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_skid_data[r_wptr] <= ffrdata;
        r_skid_last[r_wptr] <= r_pend_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_skid_cnt <= r_skid_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  a_ffrvld_legal: assert property (@(posedge clk) disable iff (!reset_n)
    ffrvld |-> (r_state == DRAIN && r_skid_cnt != 2'd2));

endmodule

// File: tb/tb_trp_ctrl.sv
// Bench for trp_ctrl: behavioural trp_fifo responder plus a transpose scoreboard.
module tb_trp_ctrl;
  localparam int BUFFD = 8;
  localparam int W     = BUFFD*8;

  typedef logic [W-1:0] tile_t [BUFFD];

  logic         clk = 1'b0, reset_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         s_valid = 1'b0, m_ready = 1'b0;
  logic [W-1:0] s_data = '0;
  logic [W-1:0] ffrdata = '0;
  logic         ffrvld = 1'b0;
  logic         s_ready, m_valid, m_last, busy, err_mode, ffinit, ffwreq, ffrreq;
  logic [W-1:0] m_data, ffwdata;
  logic [1:0]   trp_mode;

  always #5 clk = ~clk;

  trp_ctrl #(.BUFFD(BUFFD)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_mode(err_mode), .trp_mode(trp_mode),
    .ffinit(ffinit), .ffwreq(ffwreq), .ffwdata(ffwdata),
    .ffrreq(ffrreq), .ffrdata(ffrdata), .ffrvld(ffrvld)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Column k of a tile: element i of the column is element k of row i.
  function automatic logic [W-1:0] tcol(input tile_t rows, input int k, input int esz);
    logic [W-1:0] r = '0;
    for (int i = 0; i < BUFFD/esz; i++)
      for (int b = 0; b < esz; b++)
        r[(i*esz+b)*8 +: 8] = rows[i][(k*esz+b)*8 +: 8];
    return r;
  endfunction

  // trp_fifo stand-in: stores rows from ffwdata, answers each ffrreq one cycle later.
  tile_t fmem;
  int    fw = 0, fr = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ffrvld <= 1'b0;
      fw     <= 0;
      fr     <= 0;
    end else begin
      ffrvld <= ffrreq;
      if (ffinit) begin
        fw <= 0;
        fr <= 0;
      end
      if (ffwreq && fw < BUFFD) begin
        fmem[fw] <= ffwdata;
        fw       <= fw + 1;
      end
      if (ffrreq) begin
        ffrdata <= tcol(fmem, fr, (trp_mode == 2'b10) ? 4 : 1);
        fr      <= fr + 1;
      end
    end
  end

  // Scoreboard driven from the tile the stimulus sent, not from what the DUT wrote.
  tile_t tile;
  int    exp_n = 0, exp_esz = 1, out_idx = 0;
  int    n_init = 0, n_wr = 0, n_rd = 0;
  bit    m_rand = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ffinit) n_init++;
      if (ffrreq) n_rd++;
      if (ffwreq) begin
        n_wr++;
        chk("ffwdata", ffwdata, s_data);
      end
      if (m_valid && m_ready) begin
        if (out_idx >= exp_n) chk("extra_beat", W'(out_idx), W'(exp_n - 1));
        else begin
          chk("m_data", m_data, tcol(tile, out_idx, exp_esz));
          chk("m_last", W'(m_last), W'(out_idx == exp_n - 1));
          out_idx++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (m_rand) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_row(input logic [W-1:0] d, input bit gaps);
    bit acc;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (t > 50) begin
        chk("accept_timeout", W'(acc), W'(1));
        break;
      end
    end
  endtask

  task automatic run_tile(input logic [1:0] md, input bit pattern, input bit rnd, input bit stall);
    int esz = (md == 2'b10) ? 4 : 1;
    int n   = BUFFD / esz;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < BUFFD; j++)
        tile[i][j*8 +: 8] = pattern ? {4'(i), 4'(j)} : 8'($urandom);
    exp_n = n; exp_esz = esz; out_idx = 0;
    n_init = 0; n_wr = 0; n_rd = 0;
    mode = md;
    for (int r = 0; r < n; r++) begin
      send_row(tile[r], rnd);
      if (r == 0 && rnd) mode = 2'($urandom);
    end
    s_valid = 1'b0;
    if (stall) begin
      repeat (10) @(posedge clk);
      #1;
      chk("stall_rreq", W'(n_rd), W'(2));
      chk("stall_mvalid", W'(m_valid), W'(1));
      m_ready = 1'b1;
    end
    for (int t = 0; t < 300; t++) begin
      if (out_idx == exp_n) break;
      @(posedge clk); #1;
    end
    chk("tile_beats", W'(out_idx), W'(n));
    chk("busy_end", W'(busy), W'(0));
    chk("n_init", W'(n_init), W'(1));
    chk("n_wr", W'(n_wr), W'(n));
    chk("n_rd", W'(n_rd), W'(n));
    chk("trp_mode", W'(trp_mode), W'(md));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, W'({s_ready, m_valid, m_last, busy, err_mode, trp_mode, ffinit, ffwreq, ffrreq}), '0);
    chk({tag, "_wdata"}, ffwdata, '0);
    chk({tag, "_mdata"}, m_data, '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    m_ready = 1'b1;
    run_tile(2'b01, 1'b1, 1'b0, 1'b0);
    run_tile(2'b10, 1'b0, 1'b0, 1'b0);

    m_ready = 1'b0;
    run_tile(2'b01, 1'b0, 1'b0, 1'b1);

    // Illegal mode: single-cycle s_valid in IDLE
    n_init = 0;
    mode = 2'b11;
    s_valid = 1'b1;
    @(negedge clk);
    chk("err_pulse", W'(err_mode), W'(1));
    chk("err_sready", W'(s_ready), W'(0));
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("err_clear", W'(err_mode), W'(0));
    chk("err_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    chk("err_noinit", W'(n_init), W'(0));

    // Reset after 3 FILL beats, then a full tile from row 0
    mode = 2'b01;
    for (int r = 0; r < 3; r++) send_row(W'({$urandom, $urandom}), 1'b0);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    run_tile(2'b01, 1'b1, 1'b0, 1'b0);

    m_rand = 1'b1;
    run_tile(2'b01, 1'b0, 1'b1, 1'b0);
    run_tile(2'b10, 1'b0, 1'b1, 1'b0);
    run_tile(2'b10, 1'b0, 1'b1, 1'b0);
    run_tile(2'b01, 1'b0, 1'b1, 1'b0);
    m_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
